// File: rtl/stop_light_pkg.sv
// stop_light_pkg: phase encoding, fault codes and default dwell counts shared by
// the stop-light controller and its monitor.
package stop_light_pkg;
    typedef enum logic [2:0] {PH_SYNC, PH_LEFT, PH_GREEN, PH_AMBER, PH_RED} phase_t;
    localparam logic [2:0] FC_NONE = 3'd0, FC_ILLEGAL = 3'd1, FC_ORDER = 3'd2,
                           FC_SHORT = 3'd3, FC_LONG = 3'd4;
    localparam int DEF_LEFT_STEPS = 2, DEF_GREEN_STEPS = 3, DEF_AMBER_STEPS = 1, DEF_RED_STEPS = 5;
    // lamp vector order is {Red, Amber, Green, LeftGreen}
    function automatic logic [3:0] lamp_of(phase_t p);
        return p == PH_LEFT ? 4'b0001 : p == PH_GREEN ? 4'b0010 :
               p == PH_AMBER ? 4'b0100 : p == PH_RED ? 4'b1000 : 4'b0000;
    endfunction
    function automatic phase_t succ_of(phase_t p);
        return p == PH_LEFT ? PH_GREEN : p == PH_GREEN ? PH_AMBER :
               p == PH_AMBER ? PH_RED : p == PH_RED ? PH_LEFT : PH_SYNC;
    endfunction
endpackage

// File: rtl/stop_light_monitor_if.sv
// stop_light_monitor_if: observed lamps in, decoded monitor status out.
interface stop_light_monitor_if;
    logic       LeftGreen, Green, Amber, Red;
    logic [2:0] phase;
    logic       synced;
    logic [3:0] dwell;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] cycle_cnt;
    modport master (output LeftGreen, Green, Amber, Red,
                    input phase, synced, dwell, fault, fault_code, cycle_cnt);
    modport slave  (input LeftGreen, Green, Amber, Red,
                    output phase, synced, dwell, fault, fault_code, cycle_cnt);
endinterface

// File: rtl/stop_light_dwell_ctr.sv
// stop_light_dwell_ctr: 4-bit dwell counter (clear > load-1 > increment) with limit compare.
module stop_light_dwell_ctr (
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       load,
    input  logic       inc,
    input  logic [3:0] limit,
    output logic [3:0] cnt,
    output logic       at_limit
);
    always_ff @(posedge CLK or posedge RST)
        if (RST)       cnt <= 4'd0;
        else if (clr)  cnt <= 4'd0;
        else if (load) cnt <= 4'd1;
        else if (inc)  cnt <= cnt + 4'd1;
    assign at_limit = cnt == limit;
endmodule

// File: rtl/stop_light_monitor.sv
// stop_light_monitor: tracks the LEFT-GREEN-AMBER-RED lamp sequence, checks dwell
// times, latches the first fault and counts complete correct cycles.
module stop_light_monitor import stop_light_pkg::*; #(
    parameter int LEFT_STEPS  = DEF_LEFT_STEPS,
    parameter int GREEN_STEPS = DEF_GREEN_STEPS,
    parameter int AMBER_STEPS = DEF_AMBER_STEPS,
    parameter int RED_STEPS   = DEF_RED_STEPS
) (
    input logic CLK,
    input logic RST,
    stop_light_monitor_if.slave bus
);
    phase_t     state, state_n;
    logic [3:0] cur, prev, limit, dwell;
    logic       legal, same, succ, go, at_lim, clr, load, inc, viol, fault;
    logic [2:0] code_n, fault_code;
    logic [7:0] cycle_cnt;

    assign cur = {bus.Red, bus.Amber, bus.Green, bus.LeftGreen};

    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= PH_SYNC;
        else     state <= state_n;

    always_comb begin
        limit = state == PH_LEFT ? 4'(LEFT_STEPS) : state == PH_GREEN ? 4'(GREEN_STEPS) :
                state == PH_AMBER ? 4'(AMBER_STEPS) : 4'(RED_STEPS);
        legal = $onehot(cur);
        same = cur == lamp_of(state);
        succ = cur == lamp_of(succ_of(state));
        go = state == PH_SYNC && prev == 4'b1000 && cur == 4'b0001;
        // a successor lamp can only arrive early, since dwell never passes the limit
        code_n = state == PH_SYNC ? FC_NONE : !legal ? FC_ILLEGAL : !(same || succ) ? FC_ORDER :
                 succ && !at_lim ? FC_SHORT : same && at_lim ? FC_LONG : FC_NONE;
        viol = code_n != FC_NONE;
        state_n = viol ? PH_SYNC : go ? PH_LEFT : succ ? succ_of(state) : state;
        clr = viol || (state == PH_SYNC && !go);
        load = go || (state != PH_SYNC && succ);
        inc = state != PH_SYNC && same;
    end

    stop_light_dwell_ctr u_dwell (
        .CLK(CLK), .RST(RST), .clr(clr), .load(load), .inc(inc),
        .limit(limit), .cnt(dwell), .at_limit(at_lim)
    );

    // reaching RED while synced implies LEFT, GREEN, AMBER were all walked in order
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            prev       <= 4'b0000;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            cycle_cnt  <= 8'd0;
        end else begin
            prev  <= cur;
            fault <= fault | viol;
            if (viol && !fault) fault_code <= code_n;
            if (state == PH_RED && succ && !viol && cycle_cnt != 8'hFF) cycle_cnt <= cycle_cnt + 8'd1;
        end

    assign bus.phase      = state;
    assign bus.synced     = state != PH_SYNC;
    assign bus.dwell      = dwell;
    assign bus.fault      = fault;
    assign bus.fault_code = fault_code;
    assign bus.cycle_cnt  = cycle_cnt;
endmodule

// File: tb/tb_stop_light_monitor.sv
// tb_stop_light_monitor: table-driven directed vectors for the stop-light monitor.
module tb_stop_light_monitor;
    import stop_light_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    stop_light_monitor_if bus();
    stop_light_monitor dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [3:0] lamps;
        logic [2:0] ph;
        logic [3:0] dw;
        logic       f;
        logic [2:0] code;
        logic [7:0] cnt;
    } vec_t;

    localparam logic [3:0] L = 4'b0001, G = 4'b0010, A = 4'b0100, R = 4'b1000;
    localparam logic [3:0] GA = 4'b0110, Z = 4'b0000;

    vec_t vq[$];
    int checks = 0, fails = 0;

    function automatic void add(logic r, logic [3:0] lm, int ph, int dw, int f, int code, int cnt);
        vec_t v;
        v.rst = r; v.lamps = lm; v.ph = 3'(ph); v.dw = 4'(dw);
        v.f = f[0]; v.code = 3'(code); v.cnt = 8'(cnt);
        vq.push_back(v);
    endfunction

    // n fault-free L,G,A,R cycles after a lone Red; cycle c has c earlier cycles completed
    function automatic void add_cycles(int n);
        int st[4] = '{DEF_LEFT_STEPS, DEF_GREEN_STEPS, DEF_AMBER_STEPS, DEF_RED_STEPS};
        for (int c = 0; c < n; c++)
            for (int p = 0; p < 4; p++)
                for (int d = 1; d <= st[p]; d++)
                    add(0, 4'(1 << p), p + 1, d, 0, 0, c > 255 ? 255 : c);
    endfunction

    task automatic check(string name, vec_t v);
        checks++;
        if ({bus.phase, bus.dwell, bus.fault, bus.fault_code, bus.cycle_cnt} !==
            {v.ph, v.dw, v.f, v.code, v.cnt}) begin
            fails++;
            $display("FAIL %s: got phase=%0d dwell=%0d fault=%0d code=%0d cnt=%0d, want phase=%0d dwell=%0d fault=%0d code=%0d cnt=%0d",
                     name, bus.phase, bus.dwell, bus.fault, bus.fault_code, bus.cycle_cnt,
                     v.ph, v.dw, v.f, v.code, v.cnt);
        end
        checks++;
        if (bus.synced !== (v.ph != 3'd0)) begin
            fails++;
            $display("FAIL %s synced: got %0b, want %0b", name, bus.synced, v.ph != 3'd0);
        end
    endtask

    task automatic run(int i, vec_t v);
        {bus.Red, bus.Amber, bus.Green, bus.LeftGreen} = v.lamps;
        if (v.rst) begin
            RST = 1'b1;
            #1 check($sformatf("vec%0d_rst", i), v);
            RST = 1'b0;
        end else begin
            @(posedge CLK);
            #1 check($sformatf("vec%0d", i), v);
        end
    endtask

    initial begin
        {bus.Red, bus.Amber, bus.Green, bus.LeftGreen} = Z;
        // nominal: three cycles, two RED->LEFT completions
        add(1, Z, 0, 0, 0, 0, 0);
        add(0, R, 0, 0, 0, 0, 0);
        add_cycles(3);
        // dwell short: Green held 2 then Amber
        add(0, L, 1, 1, 0, 0, 3); add(0, L, 1, 2, 0, 0, 3);
        add(0, G, 2, 1, 0, 0, 3); add(0, G, 2, 2, 0, 0, 3);
        add(0, A, 0, 0, 1, 3, 3);
        // resync, then an illegal encoding keeps the first code
        add(0, R, 0, 0, 1, 3, 3); add(0, L, 1, 1, 1, 3, 3);
        add(0, GA, 0, 0, 1, 3, 3);
        // dwell long: Amber held 2
        add(1, Z, 0, 0, 0, 0, 0); add(0, R, 0, 0, 0, 0, 0);
        add(0, L, 1, 1, 0, 0, 0); add(0, L, 1, 2, 0, 0, 0);
        add(0, G, 2, 1, 0, 0, 0); add(0, G, 2, 2, 0, 0, 0); add(0, G, 2, 3, 0, 0, 0);
        add(0, A, 3, 1, 0, 0, 0); add(0, A, 0, 0, 1, 4, 0);
        // illegal Green+Amber in GREEN, then order error and all-low keep code 1
        add(1, Z, 0, 0, 0, 0, 0); add(0, R, 0, 0, 0, 0, 0);
        add(0, L, 1, 1, 0, 0, 0); add(0, L, 1, 2, 0, 0, 0); add(0, G, 2, 1, 0, 0, 0);
        add(0, GA, 0, 0, 1, 1, 0);
        add(0, R, 0, 0, 1, 1, 0); add(0, L, 1, 1, 1, 1, 0); add(0, A, 0, 0, 1, 1, 0);
        add(0, R, 0, 0, 1, 1, 0); add(0, L, 1, 1, 1, 1, 0); add(0, Z, 0, 0, 1, 1, 0);
        // reset mid-RED at dwell 3, then LeftGreen without a fresh Red stays in SYNC
        add(1, Z, 0, 0, 0, 0, 0); add(0, R, 0, 0, 0, 0, 0);
        add(0, L, 1, 1, 0, 0, 0); add(0, L, 1, 2, 0, 0, 0);
        add(0, G, 2, 1, 0, 0, 0); add(0, G, 2, 2, 0, 0, 0); add(0, G, 2, 3, 0, 0, 0);
        add(0, A, 3, 1, 0, 0, 0);
        add(0, R, 4, 1, 0, 0, 0); add(0, R, 4, 2, 0, 0, 0); add(0, R, 4, 3, 0, 0, 0);
        add(1, R, 0, 0, 0, 0, 0);
        add(0, L, 0, 0, 0, 0, 0); add(0, L, 0, 0, 0, 0, 0);
        add(0, R, 0, 0, 0, 0, 0); add(0, L, 1, 1, 0, 0, 0);
        // Red->Green from SYNC is not an entry
        add(1, Z, 0, 0, 0, 0, 0); add(0, R, 0, 0, 0, 0, 0); add(0, G, 0, 0, 0, 0, 0);
        // saturation: 260 cycles
        add(1, Z, 0, 0, 0, 0, 0); add(0, R, 0, 0, 0, 0, 0);
        add_cycles(260);
        add(0, L, 1, 1, 0, 0, 255);

        foreach (vq[i]) run(i, vq[i]);

        // reset held across clock edges keeps everything cleared
        {bus.Red, bus.Amber, bus.Green, bus.LeftGreen} = R;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 check("rst_held", '{1'b1, R, 3'd0, 4'd0, 1'b0, 3'd0, 8'd0});
        RST = 1'b0;
        {bus.Red, bus.Amber, bus.Green, bus.LeftGreen} = L;
        @(posedge CLK);
        #1 check("rst_held_left", '{1'b0, L, 3'd0, 4'd0, 1'b0, 3'd0, 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/stop_light_monitor.md
STOP_LIGHT_MONITOR -- requirements
Module: stop_light_monitor

Interface
REQ-001 Parameters SHALL be:
- LEFT_STEPS, 2, required LeftGreen dwell in clocks.
- GREEN_STEPS, 3, required Green dwell.
- AMBER_STEPS, 1, required Amber dwell.
- RED_STEPS, 5, required Red dwell.
- All four SHALL be 1..15.
REQ-002 Ports SHALL be:
- CLK  input  1  sole clock; rising edge.
- RST  input  1  asynchronous, active-high reset.
- LeftGreen  input  1  observed turn-arrow lamp.
- Green  input  1  observed green lamp.
- Amber  input  1  observed amber lamp.
- Red  input  1  observed red lamp.
- phase  output  3  decoded phase: 0 SYNC, 1 LEFT, 2 GREEN, 3 AMBER, 4 RED.
- synced  output  1  high whenever phase != SYNC.
- dwell  output  4  clocks spent in current phase, including the current sample.
- fault  output  1  sticky; set on the first violation.
- fault_code  output  3  code of the first violation: 0 none, 1 illegal lamp encoding, 2 wrong order, 3 dwell short, 4 dwell long.
- cycle_cnt  output  8  count of complete, correct LEFT-GREEN-AMBER-RED cycles; saturates at 255.

Function
REQ-003 Sampling and latency:
- Lamps SHALL be sampled on every rising CLK edge.
- All outputs SHALL be registered and SHALL reflect the sample taken at that edge; latency is 1 clock.
REQ-004 Legal encoding: exactly one lamp high; any other combination, including all-low, SHALL be illegal.
REQ-005 The SHALL keep the previous sample in a register, prev, reset to 0000.
REQ-006 SYNC behaviour:
- Lamps SHALL NOT be checked.
- Exit to LEFT SHALL occur only when prev is Red-only and the current sample is LeftGreen-only; dwell SHALL load 1.
REQ-007 In a synced phase, the next sample SHALL be classified as:
- Same lamp as the current phase: stay; dwell increments.
- Lamp of the successor phase (LEFT->GREEN->AMBER->RED->LEFT): transition; dwell loads 1.
- Anything else: violation.
REQ-008 Dwell long: a same-lamp sample taken while dwell already equals the phase parameter SHALL be a violation (code 4).
REQ-009 Dwell short: a successor transition taken while dwell is below the parameter SHALL be a violation (code 3).
REQ-010 Wrong order: a legal encoding that is neither the same lamp nor the successor lamp SHALL be a violation (code 2).
REQ-011 Illegal encoding while synced SHALL be a violation (code 1).
REQ-012 Violation priority within one sample SHALL be 1 > 2 > 3 > 4.
REQ-013 On any violation:
- fault SHALL set.
- fault_code SHALL load the code only if fault was previously 0, so the first fault is kept.
- phase SHALL return to SYNC and dwell SHALL clear to 0.
- Resynchronisation SHALL then proceed per REQ-006.
REQ-014 cycle_cnt SHALL increment on a correct RED->LEFT transition (dwell == RED_STEPS), but only if the preceding LEFT, GREEN and AMBER phases were all entered without an intervening SYNC; it SHALL hold at 255.
REQ-015 Regardless of fault, cycle_cnt SHALL keep counting after resynchronisation.
REQ-016 dwell SHALL never exceed 15; this follows from REQ-008 and the parameter range.

Reset
REQ-017 While RST is high, the following SHALL hold regardless of CLK: phase=0, synced=0, dwell=0, fault=0, fault_code=0, cycle_cnt=0, prev=0000.
REQ-018 RST asserted mid-phase SHALL discard all state; after release, the first LEFT is accepted only after a fresh Red->LeftGreen edge.

Structure
REQ-019 A shared package stop_light_pkg SHALL hold:
- the phase enumeration;
- the fault-code constants;
- the default step counts, also used by the light controller.
REQ-020 One sub-module, stop_light_dwell_ctr, SHALL hold the 4-bit load/increment/clear counter with its ==limit compare; the phase FSM and fault logic SHALL reside in the top.

Verification
REQ-021 Directed scenarios:
- Nominal: drive the controller sequence (L×2, G×3, A×1, R×5) for 3 cycles after one Red sample -> fault=0; cycle_cnt=2 (the first cycle is entered from SYNC and is counted); phase tracks with 1-clock latency.
- Dwell short: Green held 2 clocks, then Amber -> fault=1, fault_code=3, phase=0 on the next clock.
- Dwell long: Amber held 2 clocks -> fault_code=4 on the second Amber sample.
- Illegal encoding: Green+Amber high together in GREEN -> fault_code=1. A subsequent order error -> fault_code stays 1.
- Reset mid-RED with dwell=3 -> all outputs 0. After release, LeftGreen-only without a preceding Red sample -> phase stays 0.
- Saturation: 260 correct cycles -> cycle_cnt=255, fault=0.
